// File: rtl/uart_rx_bytes_if.sv
// uart_rx_bytes_if
//   Bundles the serial input and the received-byte outputs of uart_rx_bytes.
//   Optional macro: UART_RX_PARITY_EN adds the parity_err strobe.
//
//   Signals:
//     rxd        serial line into the receiver (idle high)
//     data_out   last good byte received
//     data_valid one-cycle strobe when data_out updates
//     frame_err  one-cycle strobe when a stop bit is sampled low
//     busy       receiver is inside a frame
//     parity_err one-cycle strobe on even-parity failure (UART_RX_PARITY_EN only)
//
//   Modports:
//     master  line driver / byte consumer side
//     slave   the receiver itself
interface uart_rx_bytes_if;
  logic       rxd;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;

  modport master (output rxd, input data_out, data_valid, frame_err, busy, parity_err);
  modport slave  (input rxd, output data_out, data_valid, frame_err, busy, parity_err);
`else
  modport master (output rxd, input data_out, data_valid, frame_err, busy);
  modport slave  (input rxd, output data_out, data_valid, frame_err, busy);
`endif
endinterface

// File: rtl/uart_rx_bytes.sv
// uart_rx_bytes
//   Receive end of the serial link.
//   - Synchronises rxd through two flops.
//   - Validates the start bit at mid-bit.
//   - Samples the data bits LSB first at mid-bit and checks the stop bit.
//   - Presents each good byte with a one-cycle data_valid strobe.
//   - A held-low line after a bad stop bit yields a single frame_err.
//   Bit timing is derived from the system clock: DIV = FREQ_INPUT / BAUD cycles per bit.
//   Optional macro: UART_RX_PARITY_EN selects 8E1 framing and the parity_err output.
//
//   Ports:
//     i_clksrc  system clock, rising edge
//     i_rst     synchronous active-high reset
//     rx_bus    uart_rx_bytes_if.slave (rxd in; data_out, data_valid, frame_err,
//               busy [, parity_err] out)
module uart_rx_bytes #(
  parameter int FREQ_INPUT = 500_000,
  parameter int BAUD       = 50_000
) (
  input  logic           i_clksrc,
  input  logic           i_rst,
  uart_rx_bytes_if.slave rx_bus
);

  localparam int DIV  = FREQ_INPUT / BAUD;
  localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HALF = DIV / 2;

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);

  // Fewer than four clocks per bit leaves no room to find the middle of a bit.
  generate
    if (DIV < 4) begin : g_divCheck
      $error("uart_rx_bytes: FREQ_INPUT/BAUD must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t        r_state;
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bitIdx;
  logic [7:0]    r_shift;
  logic [7:0]    r_dataOut;
  logic          r_dataValid;
  logic          r_frameErr;
  logic          r_busy;

  state_t        w_stateNxt;
  logic [CW-1:0] w_cntNxt;
  logic [CW-1:0] w_cntInc;
  logic [2:0]    w_bitIdxNxt;
  logic [7:0]    w_shiftNxt;
  logic [7:0]    w_dataOutNxt;
  logic          w_dataValidNxt;
  logic          w_frameErrNxt;
  logic          w_rxs;

`ifdef UART_RX_PARITY_EN
  logic          r_parityBit;
  logic          r_parityErr;
  logic          w_parityBitNxt;
  logic          w_parityErrNxt;
`endif

  assign w_rxs    = r_sync[1];
  assign w_cntInc = r_cnt + CW'(1);

  // Next-state and datapath decisions; every sample point is a counter match.
  always_comb begin
    w_stateNxt     = r_state;
    w_cntNxt       = r_cnt;
    w_bitIdxNxt    = r_bitIdx;
    w_shiftNxt     = r_shift;
    w_dataOutNxt   = r_dataOut;
    w_dataValidNxt = 1'b0;
    w_frameErrNxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_parityBitNxt = r_parityBit;
    w_parityErrNxt = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (!w_rxs) begin
          w_cntNxt   = '0;
          w_stateNxt = S_START;
        end
      end
      S_START: begin
        // Re-check the line half a bit in so short glitches are rejected.
        if (r_cnt == CNT_MID) begin
          if (w_rxs) begin
            w_stateNxt = S_IDLE;
          end else begin
            w_cntNxt    = '0;
            w_bitIdxNxt = '0;
            w_stateNxt  = S_DATA;
          end
        end else begin
          w_cntNxt = w_cntInc;
        end
      end
      S_DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_cntNxt             = '0;
          w_shiftNxt[r_bitIdx] = w_rxs;
          if (r_bitIdx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_stateNxt = S_PARITY;
`else
            w_stateNxt = S_STOP;
`endif
          end else begin
            w_bitIdxNxt = r_bitIdx + 3'd1;
          end
        end else begin
          w_cntNxt = w_cntInc;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (r_cnt == CNT_LAST) begin
          w_cntNxt       = '0;
          w_parityBitNxt = w_rxs;
          w_stateNxt     = S_STOP;
        end else begin
          w_cntNxt = w_cntInc;
        end
      end
`endif
      S_STOP: begin
        // Leaving at mid-stop gives half a bit of margin for the next start edge.
        if (r_cnt == CNT_LAST) begin
          w_cntNxt = '0;
          if (w_rxs) begin
            w_stateNxt = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (^{r_shift, r_parityBit}) begin
              w_parityErrNxt = 1'b1;
            end else begin
              w_dataOutNxt   = r_shift;
              w_dataValidNxt = 1'b1;
            end
`else
            w_dataOutNxt   = r_shift;
            w_dataValidNxt = 1'b1;
`endif
          end else begin
            w_frameErrNxt = 1'b1;
            w_stateNxt    = S_BREAK;
          end
        end else begin
          w_cntNxt = w_cntInc;
        end
      end
      S_BREAK: begin
        // Stay here while the line is held low so a break reports only once.
        if (w_rxs) begin
          w_stateNxt = S_IDLE;
        end
      end
      default: begin
        w_stateNxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clksrc) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_sync      <= 2'b11;
      r_cnt       <= '0;
      r_bitIdx    <= '0;
      r_shift     <= '0;
      r_dataOut   <= '0;
      r_dataValid <= 1'b0;
      r_frameErr  <= 1'b0;
      r_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parityBit <= 1'b0;
      r_parityErr <= 1'b0;
`endif
    end else begin
      r_state     <= w_stateNxt;
      r_sync      <= {r_sync[0], rx_bus.rxd};
      r_cnt       <= w_cntNxt;
      r_bitIdx    <= w_bitIdxNxt;
      r_shift     <= w_shiftNxt;
      r_dataOut   <= w_dataOutNxt;
      r_dataValid <= w_dataValidNxt;
      r_frameErr  <= w_frameErrNxt;
      r_busy      <= (w_stateNxt != S_IDLE);
`ifdef UART_RX_PARITY_EN
      r_parityBit <= w_parityBitNxt;
      r_parityErr <= w_parityErrNxt;
`endif
    end
  end

  assign rx_bus.data_out   = r_dataOut;
  assign rx_bus.data_valid = r_dataValid;
  assign rx_bus.frame_err  = r_frameErr;
  assign rx_bus.busy       = r_busy;
`ifdef UART_RX_PARITY_EN
  assign rx_bus.parity_err = r_parityErr;
`endif

endmodule

// File: tb/tb_uart_rx_bytes.sv
// tb_uart_rx_bytes
//   Self-checking bench for uart_rx_bytes at the default 10 clocks per bit.
//   A negedge monitor records every strobe as an event.
//   Each test phase compares the recorded events against expected events, which come from:
//     - a fixed vector table,
//     - hand-written corner sequences,
//     - a frame-level reference model fed with random frames.
//   Transmitter rates are spread across +/-3%.
//   Optional macro: UART_RX_PARITY_EN (8E1 framing, parity_err checks).
`timescale 1ns/1ps
module tb_uart_rx_bytes;

`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int K_VALID = 0;
  localparam int K_FERR  = 1;
  localparam int K_PERR  = 2;

  typedef struct {
    int         kind;
    logic [7:0] dout;
  } evt_t;

  typedef struct {
    logic [7:0] data;
    bit         stopOk;
    bit         parOk;
    int         bitLenT;
    int         gap;
    int         expKind;
    logic [7:0] expData;
  } vec_t;

  logic clksrc = 1'b0;
  logic rst    = 1'b1;
  int   total  = 0;
  int   bad    = 0;

  uart_rx_bytes_if bus ();

  uart_rx_bytes #(.FREQ_INPUT(500_000), .BAUD(50_000)) dut (
    .i_clksrc (clksrc),
    .i_rst    (rst),
    .rx_bus   (bus)
  );

  always #5 clksrc = ~clksrc;

  evt_t       gotQ[$];
  evt_t       expQ[$];
  logic [7:0] lastGood = 8'h00;
  int         busyCycles = 0;
  int         overlapCnt = 0;
  int         widthViol  = 0;
  logic       prevDv = 1'b0;
  logic       prevFe = 1'b0;
  logic       prevPe = 1'b0;
  logic       curPe;

  // Record strobes as events and watch for overlapping or stretched pulses.
  always @(negedge clksrc) begin
`ifdef UART_RX_PARITY_EN
    curPe = bus.parity_err;
`else
    curPe = 1'b0;
`endif
    if (!rst) begin
      if (bus.data_valid) gotQ.push_back(evt_t'{K_VALID, bus.data_out});
      if (bus.frame_err)  gotQ.push_back(evt_t'{K_FERR, bus.data_out});
      if (curPe)          gotQ.push_back(evt_t'{K_PERR, bus.data_out});
      if (bus.busy) busyCycles++;
      if ((bus.data_valid && bus.frame_err) || (bus.data_valid && curPe) || (bus.frame_err && curPe))
        overlapCnt++;
      if ((bus.data_valid && prevDv) || (bus.frame_err && prevFe) || (curPe && prevPe))
        widthViol++;
    end
    prevDv = bus.data_valid;
    prevFe = bus.frame_err;
    prevPe = curPe;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: a frame either delivers its byte or reports an error with data_out held.
  function automatic void modelFrame(input logic [7:0] d, input bit stopOk, input bit parOk);
    if (!stopOk) begin
      expQ.push_back(evt_t'{K_FERR, lastGood});
    end else if (!parOk) begin
      expQ.push_back(evt_t'{K_PERR, lastGood});
    end else begin
      lastGood = d;
      expQ.push_back(evt_t'{K_VALID, d});
    end
  endfunction

  task automatic compareEvents(input string tag);
    checkOutput({tag, "_count"}, gotQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
      checkOutput($sformatf("%s_kind%0d", tag, i), gotQ[i].kind, expQ[i].kind);
      checkOutput($sformatf("%s_data%0d", tag, i), {24'd0, gotQ[i].dout}, {24'd0, expQ[i].dout});
    end
    gotQ.delete();
    expQ.delete();
  endtask

  task automatic driveLine(input logic level, input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clksrc);
      #1 bus.rxd = level;
    end
  endtask

  // Drive one frame; bitLenT is the bit period in tenths of a clock (100 = nominal).
  task automatic applyStimulus(input logic [7:0] d, input bit stopOk, input bit parOk,
                               input int bitLenT, input int maxCycles);
    logic [NBITS-1:0] bits;
    int len;
`ifdef UART_RX_PARITY_EN
    bits = {stopOk, (^d) ^ ~parOk, d, 1'b0};
`else
    bits = {stopOk, d, 1'b0};
`endif
    len = (NBITS * bitLenT + 9) / 10;
    for (int c = 0; c < len && c < maxCycles; c++) begin
      @(posedge clksrc);
      #1 bus.rxd = bits[(c * 10) / bitLenT];
    end
  endtask

  vec_t       vecs[8];
  logic [7:0] rd;
  bit         rStop;
  bit         rPar;
  int         rLen;
  int         rGap;
  int         b0;

  initial begin
    vecs[0] = '{8'h00, 1'b1, 1'b1, 100,  0, K_VALID, 8'h00};
    vecs[1] = '{8'hFF, 1'b1, 1'b1, 100,  0, K_VALID, 8'hFF};
    vecs[2] = '{8'h3C, 1'b1, 1'b1, 100, 20, K_VALID, 8'h3C};
    vecs[3] = '{8'h81, 1'b0, 1'b1, 100, 20, K_FERR,  8'h3C};
    vecs[4] = '{8'h55, 1'b1, 1'b1,  97,  0, K_VALID, 8'h55};
    vecs[5] = '{8'hAA, 1'b1, 1'b1, 103,  5, K_VALID, 8'hAA};
    vecs[6] = '{8'h01, 1'b1, 1'b1, 100,  0, K_VALID, 8'h01};
    vecs[7] = '{8'h80, 1'b1, 1'b1, 103, 20, K_VALID, 8'h80};

    bus.rxd = 1'b1;
    rst     = 1'b1;
    repeat (2) @(posedge clksrc);
    @(negedge clksrc);
    checkOutput("rst_data_out",   {24'd0, bus.data_out}, 32'h0);
    checkOutput("rst_data_valid", {31'd0, bus.data_valid}, 32'h0);
    checkOutput("rst_frame_err",  {31'd0, bus.frame_err}, 32'h0);
    checkOutput("rst_busy",       {31'd0, bus.busy}, 32'h0);
    @(posedge clksrc);
    #1 rst = 1'b0;

    // Idle line after reset.
    b0 = busyCycles;
    driveLine(1'b1, 200);
    compareEvents("idle");
    checkOutput("idle_busy_cycles", busyCycles - b0, 0);
    checkOutput("idle_data_out", {24'd0, bus.data_out}, 32'h0);

    // Single nominal frame; busy should span roughly 95 cycles.
    b0 = busyCycles;
    applyStimulus(8'hA5, 1'b1, 1'b1, 100, 1000);
    driveLine(1'b1, 30);
    modelFrame(8'hA5, 1'b1, 1'b1);
    compareEvents("single");
    $display("[TB] single frame busy cycles = %0d", busyCycles - b0);
    checkOutput("single_busy_span", {31'd0, (busyCycles - b0 >= 93) && (busyCycles - b0 <= 97)}, 32'h1);
    checkOutput("single_data_out", {24'd0, bus.data_out}, 32'hA5);
    checkOutput("single_busy_low", {31'd0, bus.busy}, 32'h0);

    // Vector table: back-to-back frames, framing error, skewed rates.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].data, vecs[i].stopOk, vecs[i].parOk, vecs[i].bitLenT, 1000);
      if (vecs[i].gap > 0) driveLine(1'b1, vecs[i].gap);
      expQ.push_back(evt_t'{vecs[i].expKind, vecs[i].expData});
    end
    driveLine(1'b1, 30);
    compareEvents("table");
    lastGood = vecs[7].expData;

    // Short glitch on the line: false start only.
    b0 = busyCycles;
    driveLine(1'b0, 3);
    driveLine(1'b1, 40);
    compareEvents("glitch");
    checkOutput("glitch_busy_seen", {31'd0, busyCycles > b0}, 32'h1);
    checkOutput("glitch_busy_low", {31'd0, bus.busy}, 32'h0);

    // Bad stop bit followed by a long break, then recovery.
    applyStimulus(8'h81, 1'b0, 1'b1, 100, 1000);
    modelFrame(8'h81, 1'b0, 1'b1);
    driveLine(1'b0, 300);
    checkOutput("break_busy_held", {31'd0, bus.busy}, 32'h1);
    driveLine(1'b1, 20);
    checkOutput("break_busy_released", {31'd0, bus.busy}, 32'h0);
    applyStimulus(8'h42, 1'b1, 1'b1, 100, 1000);
    modelFrame(8'h42, 1'b1, 1'b1);
    driveLine(1'b1, 30);
    compareEvents("break");
    checkOutput("break_data_out", {24'd0, bus.data_out}, 32'h42);

    // Reset in the middle of data bit 4 of 0x5A.
    applyStimulus(8'h5A, 1'b1, 1'b1, 100, 55);
    @(posedge clksrc);
    #1;
    rst     = 1'b1;
    bus.rxd = 1'b1;
    @(posedge clksrc);
    @(negedge clksrc);
    checkOutput("rstmid_busy", {31'd0, bus.busy}, 32'h0);
    checkOutput("rstmid_data_valid", {31'd0, bus.data_valid}, 32'h0);
    checkOutput("rstmid_data_out", {24'd0, bus.data_out}, 32'h0);
    @(posedge clksrc);
    #1 rst = 1'b0;
    lastGood = 8'h00;
    driveLine(1'b1, 120);
    compareEvents("rstmid");
    applyStimulus(8'hC3, 1'b1, 1'b1, 100, 1000);
    modelFrame(8'hC3, 1'b1, 1'b1);
    driveLine(1'b1, 30);
    compareEvents("rstmid_recover");

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight, so a parity bit of 0 is wrong under even parity.
    applyStimulus(8'h07, 1'b1, 1'b0, 100, 1000);
    modelFrame(8'h07, 1'b1, 1'b0);
    driveLine(1'b1, 30);
    compareEvents("parity");
    checkOutput("parity_data_out", {24'd0, bus.data_out}, {24'd0, lastGood});
`endif

    // Random frames at random rates within +/-3%.
    for (int n = 0; n < 40; n++) begin
      rd    = 8'($urandom_range(0, 255));
      rStop = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
      rPar  = ($urandom_range(0, 7) != 0);
`else
      rPar  = 1'b1;
`endif
      rLen  = int'($urandom_range(97, 103));
      rGap  = rStop ? int'($urandom_range(0, 15)) : int'($urandom_range(12, 25));
      applyStimulus(rd, rStop, rPar, rLen, 1000);
      modelFrame(rd, rStop, rPar);
      if (rGap > 0) driveLine(1'b1, rGap);
    end
    driveLine(1'b1, 40);
    compareEvents("rand");

    checkOutput("strobe_overlap", overlapCnt, 0);
    checkOutput("strobe_width", widthViol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_bytes.md
Name: uart_rx_bytes

Overview:
- Byte receiver for the UART link that the clock_div baud clock serves: the receive end of the 8N1 serial line.
- Runs on the fast system clock and derives its own per-bit sample timing from a counter; it does not use clock_div's clkout.
- Resynchronises the asynchronous rxd line, validates the start bit, samples each bit at mid-bit, checks the stop bit and presents one byte per frame with a single-cycle valid strobe.
- Sits between the board rxd pin and the byte consumer logic.

Parameters:
- FREQ_INPUT, 500_000, clksrc frequency in Hz.
- BAUD, 50_000, serial bit rate in bits/s.
- Derived DIV = FREQ_INPUT/BAUD (integer division), the number of clksrc cycles per bit. Elaboration must fail via a generate-time error if DIV < 4.

Ports:
- clksrc  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- rxd  in  1  asynchronous serial input; idle level is high.
- data_out  out  8  last received byte; holds until the next good frame.
- data_valid  out  1  one-cycle pulse when data_out updates.
- frame_err  out  1  one-cycle pulse when a stop bit is sampled low.
- busy  out  1  high from start-bit detect until the receiver returns to IDLE.

Behaviour:
- Reset values: data_out=0, data_valid=0, frame_err=0, busy=0, state=IDLE, synchroniser flops=1, counters=0.
- Synchroniser: rxd passes through 2 flops to give rxs. All decisions use rxs, which adds 2 cycles of latency.
- Bit counter: cnt is wide enough for DIV-1. bit_idx is 3 bits.
- IDLE: on rxs==0, load cnt=0, go to START, set busy=1.
- START: count to DIV/2-1 (mid start bit).
  - If rxs==1 there: false start; go to IDLE, busy=0, no pulses.
  - Otherwise clear cnt and go to DATA with bit_idx=0.
- DATA: when cnt==DIV-1, sample rxs into shift[bit_idx], LSB first, and clear cnt.
  - After bit_idx==7, go to STOP (or PARITY with the feature enabled); otherwise increment bit_idx.
- STOP: when cnt==DIV-1, sample rxs.
  - If 1: data_out<=shift and data_valid=1 on the next cycle; go to IDLE with busy=0.
  - If 0: frame_err=1 for one cycle, data_out unchanged; go to BREAK.
- BREAK: wait until rxs==1, then go to IDLE with busy=0. A held-low line (break) therefore produces exactly one frame_err, not repeated frames.
- Back-to-back frames: return to IDLE at mid-stop lets the next start edge be detected with no lost bit. A start edge arriving 0.5 bit after mid-stop must be accepted.
- data_valid and frame_err are never high in the same cycle; each is exactly 1 cycle wide.
- rst asserted mid-frame: next cycle returns all outputs and state to reset values; the partial byte is discarded.
- Sampling tolerance: receiver must decode correctly with the transmitter rate off by ±3%.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1. A PARITY state follows DATA and samples at cnt==DIV-1.
  - Adds output parity_err (1 bit), which pulses one cycle at the data_valid slot when the XOR of 8 data bits and the parity bit is 1. In that case data_valid is suppressed and data_out is unchanged.
  - A stop error still takes priority and gives frame_err only.
- Undefined: 8N1 operation, no PARITY state, no parity_err port.

Test Plan:
- Reset then idle: rst=1 for 3 cycles, rxd=1 for 200 cycles -> data_out=0, no data_valid, frame_err or busy pulses.
- Single frame: defaults (DIV=10), send 0xA5 LSB-first at 10 cycles/bit -> exactly one data_valid, data_out=0xA5; busy falls ~95 cycles after the start edge.
- Back-to-back: send 0x00, 0xFF, 0x3C with no idle gap -> three data_valid pulses with values 0x00, 0xFF, 0x3C in order.
- Glitch: rxd low for 3 cycles, then high -> busy pulses, returns to IDLE, no data_valid or frame_err.
- Framing error and break: send 0x81 with stop bit low, then hold rxd low for 300 cycles -> exactly one frame_err, data_out holds its previous value; recovery on rxd high, then 0x42 is received correctly.
- Reset mid-frame: assert rst at bit 4 of 0x5A -> no data_valid; busy=0 the cycle after rst. With UART_RX_PARITY_EN, send 0x07 with wrong parity bit 0 -> parity_err pulse, no data_valid.
